count_capture_fifo: RTL

- Downstream consumer of the free-running 8-bit sample counter in the simulation top.
- Captures a run of counter samples into a 16-entry first-word-fall-through FIFO once armed.
- A reader, the socket-driven testbench side, drains the FIFO through a valid/ready port.
- Flags overflow, counter wrap (value 255 accepted) and end of capture.

---
 rtl/count_capture_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/count_capture_fifo.sv
// Arms, captures a run of CAPTURE_LEN counter samples into a FWFT FIFO and flags overflow/wrap/done.
// Optional: define CAPTURE_SEQ_CHECK_EN to flag non-consecutive pushed samples on seq_error.
module count_capture_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int CAPTURE_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    output logic              wrap_seen,
    output logic [1:0]        state,
    output logic              done,
    output logic              seq_error
);
    // state     | meaning
    // S_IDLE    | waiting for arm
    // S_ARMED   | flushed, next sample starts the run
    // S_CAPTURE | run in progress, pushing samples
    // S_DONE    | run complete, reader drains the FIFO
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      RUN_LEN    = 8'(CAPTURE_LEN);

    state_t              cur, nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [7:0]          remain;
    logic                flush, pop, window, push, drop, last;

    always_comb begin
        flush  = arm && (cur == S_IDLE || cur == S_DONE);
        pop    = out_valid && out_ready && !flush;
        window = in_valid && (cur == S_ARMED || cur == S_CAPTURE);
        push   = window && (!full || pop);
        drop   = window && full && !pop;
        last   = push && (remain == 8'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:    if (arm) nxt = S_ARMED;
            S_ARMED:   if (push) nxt = last ? S_DONE : S_CAPTURE;
            S_CAPTURE: if (last) nxt = S_DONE;
            S_DONE: begin
                if (arm)               nxt = S_ARMED;
                else if (level == '0)  nxt = S_IDLE;
            end
            default:   nxt = S_IDLE;
        endcase
    end

    // remain counts down the samples still to accept; terminal count 1 ends the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            wrap_seen <= 1'b0;
            remain    <= 8'd0;
        end else begin
            wrap_seen <= push && (in_data == '1);
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                overflow <= 1'b0;
                remain   <= RUN_LEN;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    remain <= remain - 8'd1;
                end
                if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
                if (push && !pop)      level <= level + (ADDR_W+1)'(1);
                else if (pop && !push) level <= level - (ADDR_W+1)'(1);
                if (drop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    assign out_valid = (level != '0);
    assign full      = (level == LEVEL_FULL);
    assign out_data  = mem[rd_ptr];
    assign state     = cur;
    assign done      = (cur == S_DONE);

`ifdef CAPTURE_SEQ_CHECK_EN
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
    logic [DATA_W-1:0] prev;
    logic              seq_err;

    // the first sample of a run is pushed from S_ARMED and has no predecessor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            seq_err <= 1'b0;
        end else if (flush) begin
            seq_err <= 1'b0;
        end else if (push) begin
            prev <= in_data;
            if (cur == S_CAPTURE && in_data != prev + ONE) seq_err <= 1'b1;
        end
    end
    assign seq_error = seq_err;
`else
    assign seq_error = 1'b0;
`endif

endmodule
